board_seeder: RTL and testbench

Writer that fills the logic-side write port of the double buffer with an initial board pattern (clear, glider, pseudo-random, all-live) on request. It is the write-end counterpart of the renderer's read port: it runs in place of life_logic for one generation, then hands off. It is driven by a single start pulse and reports completion with a one-cycle done pulse, so it plugs into the synchronizer's start/done handshake unchanged.

---
 rtl/board_seeder_pkg.sv | 9 +
 rtl/board_seeder_lfsr16.sv | 14 +
 rtl/board_seeder.sv | 95 +++++++++
 tb/tb_board_seeder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/board_seeder_pkg.sv
// board_seeder_pkg: shared types and constants for the board seeder
package board_seeder_pkg;
  localparam int ADDR_W = 20;
  localparam int MAX_DATA_W = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [MAX_DATA_W-1:0] data_t;
  typedef enum logic [1:0] {CLEAR, GLIDER, RANDOM, FULL} seed_pattern_t;
endpackage

// File: rtl/board_seeder_lfsr16.sv
// lfsr16: 16-bit Galois LFSR that advances only when stepped
module lfsr16 import board_seeder_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        step_in,
  output logic [15:0] value_out
);
  // shift right, folding the taps in whenever a one drops off the end
  always_ff @(posedge clk_in)
    if (rst_in) value_out <= SEED;
    else if (step_in) value_out <= (value_out >> 1) ^ (value_out[0] ? LFSR_TAPS : 16'h0);
endmodule

// File: rtl/board_seeder.sv
// board_seeder: fills the double-buffer write port with an initial board pattern
module board_seeder import board_seeder_pkg::*; #(
  parameter int          DATA_W        = 16,
  parameter int          BOARD_W       = 1024,
  parameter int          BOARD_H       = 768,
  parameter int          GLIDER_X_WORD = 0,
  parameter int          GLIDER_Y      = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [1:0]        pattern_sel_in,
  output addr_t             addr_w_out,
  output logic [DATA_W-1:0] data_w_out,
  output logic              wr_en_out,
  output logic              busy_out,
  output logic              done_out
);
  localparam int WORDS_PER_ROW = BOARD_W / DATA_W;
  localparam int BOARD_WORDS = WORDS_PER_ROW * BOARD_H;
  localparam int WX_W = WORDS_PER_ROW > 1 ? $clog2(WORDS_PER_ROW) : 1;
  localparam int ROW_W = BOARD_H > 1 ? $clog2(BOARD_H) : 1;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t            state;
  seed_pattern_t     pat;
  addr_t             addr;
  logic [WX_W-1:0]   wx;
  logic [ROW_W-1:0]  row;
  logic [15:0]       lfsr;
  logic [15:0]       glider;
  logic [DATA_W-1:0] word;
  logic              step;
  assign step = state == FILL && pat == RANDOM;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .step_in  (step),
    .value_out(lfsr)
  );
  // glider occupies one word column over three rows; everything else is dead
  always_comb begin
    glider = wx != WX_W'(GLIDER_X_WORD) ? 16'h0000 :
             row == ROW_W'(GLIDER_Y)     ? 16'h0002 :
             row == ROW_W'(GLIDER_Y + 1) ? 16'h0004 :
             row == ROW_W'(GLIDER_Y + 2) ? 16'h0007 : 16'h0000;
    word = pat == CLEAR  ? '0 :
           pat == FULL   ? '1 :
           pat == RANDOM ? lfsr[DATA_W-1:0] : glider[DATA_W-1:0];
  end
  // control FSM: one write per FILL cycle, one done pulse, outputs registered
  always_ff @(posedge clk_in)
    if (rst_in) begin
      state      <= IDLE;
      pat        <= CLEAR;
      addr       <= '0;
      wx         <= '0;
      row        <= '0;
      addr_w_out <= '0;
      data_w_out <= '0;
      wr_en_out  <= 1'b0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
    end else
      case (state)
        IDLE: begin
          wr_en_out <= 1'b0;
          busy_out  <= 1'b0;
          done_out  <= 1'b0;
          if (start_in) begin
            pat   <= seed_pattern_t'(pattern_sel_in);
            addr  <= '0;
            wx    <= '0;
            row   <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          wr_en_out  <= 1'b1;
          busy_out   <= 1'b1;
          addr_w_out <= addr;
          data_w_out <= word;
          addr       <= addr + 1'b1;
          wx         <= wx == WX_W'(WORDS_PER_ROW - 1) ? '0 : wx + 1'b1;
          row        <= wx == WX_W'(WORDS_PER_ROW - 1) ? row + 1'b1 : row;
          if (addr == ADDR_W'(BOARD_WORDS - 1)) state <= DONE;
        end
        DONE: begin
          wr_en_out <= 1'b0;
          done_out  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_board_seeder.sv
// tb_board_seeder: randomized and directed checks of board_seeder against a pattern model
module tb_board_seeder;
  localparam int DW = 16, BWID = 32, BH = 4, GX = 0, GY = 1;
  localparam int WPR = BWID / DW;
  localparam int NW = WPR * BH;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic [1:0]  pattern_sel_in = 2'd0;
  logic [19:0] addr_w_out;
  logic [15:0] data_w_out;
  logic        wr_en_out, busy_out, done_out;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  board_seeder #(
    .DATA_W(DW), .BOARD_W(BWID), .BOARD_H(BH),
    .GLIDER_X_WORD(GX), .GLIDER_Y(GY), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .pattern_sel_in(pattern_sel_in),
    .addr_w_out    (addr_w_out),
    .data_w_out    (data_w_out),
    .wr_en_out     (wr_en_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? (x >> 1) ^ 16'hB400 : x >> 1;
  endfunction

  function automatic logic [15:0] exp_word(input logic [1:0] p, input int a);
    int r = a / WPR;
    int x = a % WPR;
    if (p == 2'd0) return 16'h0000;
    if (p == 2'd3) return 16'hFFFF;
    if (p == 2'd2) return m_lfsr;
    if (x != GX) return 16'h0000;
    return r == GY ? 16'h0002 : r == GY + 1 ? 16'h0004 : r == GY + 2 ? 16'h0007 : 16'h0000;
  endfunction

  task automatic fill(input logic [1:0] p, input int mid_at, input bit hold);
    int cyc = 0, nw = 0, nb = 0, nd = 0;
    start_in = 1'b1;
    pattern_sel_in = p;
    while (nd == 0 && cyc < 40) begin
      @(negedge clk_in);
      cyc++;
      start_in = hold;
      if (busy_out) nb++;
      if (wr_en_out) begin
        chk("addr", addr_w_out, nw);
        chk("data", data_w_out, exp_word(p, nw));
        if (p == 2'd2) m_lfsr = lfsr_next(m_lfsr);
        nw++;
        if (nw == mid_at) begin
          start_in = 1'b1;
          pattern_sel_in = 2'($urandom_range(0, 3));
        end
      end
      if (done_out) begin
        nd++;
        chk("done_wr_en", wr_en_out, 0);
        chk("done_busy", busy_out, 1);
      end
    end
    chk("writes", nw, NW);
    chk("busy_cycles", nb, NW + 1);
    chk("latency", cyc, NW + 2);
    if (!hold) begin
      @(negedge clk_in);
      chk("done_once", done_out, 0);
      chk("busy_idle", busy_out, 0);
      chk("wr_idle", wr_en_out, 0);
    end
  endtask

  initial begin
    int n, cyc;
    repeat (2) @(negedge clk_in);
    chk("rst_addr", addr_w_out, 0);
    chk("rst_data", data_w_out, 0);
    chk("rst_wr", wr_en_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    start_in = 1'b1;
    @(negedge clk_in);
    chk("rst_over_start", busy_out, 0);
    start_in = 1'b0;
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("idle_quiet", wr_en_out, 0);
    fill(2'd0, -1, 0);
    fill(2'd1, -1, 0);
    fill(2'd2, -1, 0);
    fill(2'd2, -1, 0);
    fill(2'd3, 3, 0);
    start_in = 1'b1;
    pattern_sel_in = 2'd1;
    @(negedge clk_in);
    start_in = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 20) begin
      @(negedge clk_in);
      cyc++;
      if (wr_en_out) n++;
    end
    chk("abort_reach", n, 4);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("abort_wr", wr_en_out, 0);
    chk("abort_busy", busy_out, 0);
    chk("abort_done", done_out, 0);
    rst_in = 1'b0;
    m_lfsr = 16'hACE1;
    @(negedge clk_in);
    chk("abort_no_done", done_out, 0);
    chk("abort_idle", busy_out, 0);
    fill(2'd2, -1, 0);
    repeat (6) fill(2'($urandom_range(0, 3)), int'($urandom_range(1, 8)), 0);
    fill(2'd3, -1, 1);
    fill(2'd3, -1, 1);
    start_in = 1'b0;
    @(negedge clk_in);
    chk("held_gap_wr", wr_en_out, 0);
    chk("held_gap_done", done_out, 0);
    @(negedge clk_in);
    chk("held_stop_busy", busy_out, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
